// File: rtl/ikbd_acia_if.sv
// Host-side IKBD serial link bundle: transmit handshake, serial pins,
// receive holding register, status flags and interrupt.
interface ikbd_acia_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       sdo;
   logic       sdi;
   logic [7:0] rx_data;
   logic       rx_full;
   logic       rx_rd;
   logic       fe;
   logic       ovr;
   logic       irq_en;
   logic       irq;

   // Host / bench side: drives requests and the incoming serial line.
   modport master (
      output tx_data, tx_valid, sdi, rx_rd, irq_en,
      input  tx_ready, sdo, rx_data, rx_full, fe, ovr, irq
   );

   // ACIA side.
   modport slave (
      input  tx_data, tx_valid, sdi, rx_rd, irq_en,
      output tx_ready, sdo, rx_data, rx_full, fe, ovr, irq
   );
endinterface

// File: rtl/ikbd_acia.sv
// ACIA-style serial endpoint for the IKBD link: 8N1 transmitter into the
// MCU SCI receiver, 8N1 receiver from the MCU SCI transmitter with a
// one-byte holding register, framing/overrun flags and a level interrupt.
module ikbd_acia #(
   parameter int BIT_CYCLES = 256
) (
   input logic        clk,
   input logic        res,
   ikbd_acia_if.slave bus
);

   localparam int            CW       = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] FULL_BIT = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] HALF_BIT = CW'(BIT_CYCLES / 2 - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // ---------------- transmitter state ----------------
   tx_state_t     tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q,   tx_cnt_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic [2:0]    tx_bit_q,   tx_bit_d;
   logic          sdo_q,      sdo_d;
   logic          tx_ready_q, tx_ready_d;

   // ---------------- receiver state ----------------
   logic          sdi_m_q,    sdi_m_d;
   logic          sdi_s_q,    sdi_s_d;
   rx_state_t     rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q,   rx_cnt_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic [2:0]    rx_bit_q,   rx_bit_d;
   logic [7:0]    rx_data_q,  rx_data_d;
   logic          rx_full_q,  rx_full_d;
   logic          fe_q,       fe_d;
   logic          ovr_q,      ovr_d;

   logic          stop_sample;
   logic          full_eff;

   // Transmit sequencing: every state holds sdo for one full bit period,
   // counted down from BIT_CYCLES-1 so the state advances on the edge
   // where the counter reads zero.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_shift_d = tx_shift_q;
      tx_bit_d   = tx_bit_q;
      sdo_d      = sdo_q;
      tx_ready_d = tx_ready_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (bus.tx_valid && tx_ready_q) begin
               tx_state_d = TX_START;
               tx_cnt_d   = FULL_BIT;
               tx_shift_d = bus.tx_data;
               sdo_d      = 1'b0;
               tx_ready_d = 1'b0;
            end
         end
         TX_START: begin
            if (tx_cnt_q == '0) begin
               tx_state_d = TX_DATA;
               tx_cnt_d   = FULL_BIT;
               tx_bit_d   = 3'd0;
               sdo_d      = tx_shift_q[0];
               tx_shift_d = {1'b0, tx_shift_q[7:1]};
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_ONE;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d = FULL_BIT;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
                  sdo_d      = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  sdo_d      = tx_shift_q[0];
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
               end
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_ONE;
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == '0) begin
               tx_state_d = TX_IDLE;
               tx_ready_d = 1'b1;
            end else begin
               tx_cnt_d = tx_cnt_q - CNT_ONE;
            end
         end
         default: begin
            tx_state_d = TX_IDLE;
            sdo_d      = 1'b1;
            tx_ready_d = 1'b1;
         end
      endcase
   end

   // Receive sequencing: the start bit is verified half a bit after
   // detection, then every later sample lands mid-bit one period apart.
   always_comb begin
      sdi_m_d     = bus.sdi;
      sdi_s_d     = sdi_m_q;
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_shift_d  = rx_shift_q;
      rx_bit_d    = rx_bit_q;
      stop_sample = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            if (!sdi_s_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = HALF_BIT;
            end
         end
         RX_START: begin
            if (rx_cnt_q == '0) begin
               if (sdi_s_q) begin
                  rx_state_d = RX_IDLE;          // glitch, not a start bit
               end else begin
                  rx_state_d = RX_DATA;
                  rx_cnt_d   = FULL_BIT;
                  rx_bit_d   = 3'd0;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_ONE;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_shift_d = {sdi_s_q, rx_shift_q[7:1]};
               rx_cnt_d   = FULL_BIT;
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_ONE;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == '0) begin
               stop_sample = 1'b1;
               rx_state_d  = RX_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q - CNT_ONE;
            end
         end
         default: begin
            rx_state_d = RX_IDLE;
         end
      endcase
   end

   // Holding register and flags. A read in the same cycle as a stop sample
   // frees the register first, so a good byte loads instead of overrunning,
   // while a framing error still sets fe.
   always_comb begin
      full_eff  = rx_full_q & ~bus.rx_rd;
      rx_data_d = rx_data_q;
      rx_full_d = full_eff;
      fe_d      = fe_q & ~bus.rx_rd;
      ovr_d     = ovr_q & ~bus.rx_rd;
      if (stop_sample) begin
         if (sdi_s_q) begin
            if (!full_eff) begin
               rx_data_d = rx_shift_q;
               rx_full_d = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
         end else begin
            fe_d = 1'b1;
         end
      end
   end

   // State registers; reset aborts any frame in flight and forces sdo high
   // at once.
   always_ff @(posedge clk or posedge res) begin
      if (res) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_shift_q <= 8'h00;
         tx_bit_q   <= 3'd0;
         sdo_q      <= 1'b1;
         tx_ready_q <= 1'b1;
         sdi_m_q    <= 1'b1;
         sdi_s_q    <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_shift_q <= 8'h00;
         rx_bit_q   <= 3'd0;
         rx_data_q  <= 8'h00;
         rx_full_q  <= 1'b0;
         fe_q       <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_shift_q <= tx_shift_d;
         tx_bit_q   <= tx_bit_d;
         sdo_q      <= sdo_d;
         tx_ready_q <= tx_ready_d;
         sdi_m_q    <= sdi_m_d;
         sdi_s_q    <= sdi_s_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_shift_q <= rx_shift_d;
         rx_bit_q   <= rx_bit_d;
         rx_data_q  <= rx_data_d;
         rx_full_q  <= rx_full_d;
         fe_q       <= fe_d;
         ovr_q      <= ovr_d;
      end
   end

   assign bus.sdo      = sdo_q;
   assign bus.tx_ready = tx_ready_q;
   assign bus.rx_data  = rx_data_q;
   assign bus.rx_full  = rx_full_q;
   assign bus.fe       = fe_q;
   assign bus.ovr      = ovr_q;
   assign bus.irq      = bus.irq_en & (rx_full_q | fe_q | ovr_q);

endmodule

// File: tb/tb_ikbd_acia.sv
// Scoreboard bench for ikbd_acia: stimulus pushes expected receiver states
// and transmitted bytes; two monitors pop and compare when the DUT shows them.
module tb_ikbd_acia;
   localparam int BC = 16;

   typedef struct packed {
      logic [7:0] data;
      logic       full;
      logic       fe;
      logic       ovr;
      logic       irq;
   } rx_exp_t;

   logic clk = 1'b0;
   logic res = 1'b1;
   always #5 clk = ~clk;

   ikbd_acia_if bus ();

   ikbd_acia #(.BIT_CYCLES(BC)) dut (
      .clk (clk),
      .res (res),
      .bus (bus.slave)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   rx_exp_t    rx_q[$];
   logic [7:0] tx_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("[TB] ok   %s = 0x%0h", name, act);
      end
   endtask

   task automatic wait_neg(input int n, output bit ab);
      ab = 1'b0;
      repeat (n) begin
         @(negedge clk);
         if (res) ab = 1'b1;
      end
   endtask

   // Receiver monitor: any change of the visible receive state is one event.
   initial begin
      logic [11:0] prev, cur;
      rx_exp_t     e;
      int          k;
      k = 0;
      prev = '0;
      forever begin
         @(negedge clk);
         cur = {bus.rx_data, bus.rx_full, bus.fe, bus.ovr, bus.irq};
         if (res) begin
            prev = cur;
         end else if (cur !== prev) begin
            prev = cur;
            if (rx_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("[TB] FAIL rx_unexpected: got 0x%0h, expected no change", cur);
            end else begin
               e = rx_q.pop_front();
               k++;
               chk($sformatf("rx%0d.data", k), bus.rx_data, e.data);
               chk($sformatf("rx%0d.full", k), bus.rx_full, e.full);
               chk($sformatf("rx%0d.fe", k),   bus.fe,      e.fe);
               chk($sformatf("rx%0d.ovr", k),  bus.ovr,     e.ovr);
               chk($sformatf("rx%0d.irq", k),  bus.irq,     e.irq);
            end
         end
      end
   end

   // Transmit monitor: decode sdo mid-bit, compare with the queued byte.
   initial begin
      logic       prev_sdo, st, sp;
      logic [7:0] got, e;
      bit         ab;
      prev_sdo = 1'b1;
      forever begin
         @(negedge clk);
         if (!res && prev_sdo === 1'b1 && bus.sdo === 1'b0) begin
            wait_neg(BC / 2, ab);
            st = bus.sdo;
            for (int i = 0; i < 8; i++) begin
               if (!ab) begin
                  wait_neg(BC, ab);
                  got[i] = bus.sdo;
               end
            end
            if (!ab) wait_neg(BC, ab);
            sp = bus.sdo;
            if (!ab) begin
               if (tx_q.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("[TB] FAIL tx_unexpected: got 0x%0h, expected no frame", got);
               end else begin
                  e = tx_q.pop_front();
                  chk("tx.start", st, 0);
                  chk("tx.data", got, e);
                  chk("tx.stop", sp, 1);
               end
            end
         end
         prev_sdo = bus.sdo;
      end
   end

   task automatic rx_frame(input logic [7:0] d, input logic stop_bit, input bit rd_at_stop);
      bus.sdi = 1'b0;
      repeat (BC) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.sdi = d[i];
         repeat (BC) @(negedge clk);
      end
      bus.sdi = stop_bit;
      if (rd_at_stop) begin
         // stop sample falls 10 cycles into the stop bit
         repeat (10) @(negedge clk);
         bus.rx_rd = 1'b1;
         @(negedge clk);
         bus.rx_rd = 1'b0;
         repeat (BC - 11) @(negedge clk);
      end else begin
         repeat (BC) @(negedge clk);
      end
      bus.sdi = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic rd_pulse();
      bus.rx_rd = 1'b1;
      @(negedge clk);
      bus.rx_rd = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   function automatic rx_exp_t mk(input logic [7:0] d, input logic f, input logic e,
                                  input logic o, input logic i);
      mk = {d, f, e, o, i};
   endfunction

   // Directed stimulus.
   initial begin
      int         n;
      logic [7:0] rxb;
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      bus.sdi      = 1'b1;
      bus.rx_rd    = 1'b0;
      bus.irq_en   = 1'b1;
      res          = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst.sdo", bus.sdo, 1);
      chk("rst.tx_ready", bus.tx_ready, 1);
      chk("rst.rx_data", bus.rx_data, 8'h00);
      chk("rst.rx_full", bus.rx_full, 0);
      chk("rst.fe", bus.fe, 0);
      chk("rst.ovr", bus.ovr, 0);
      chk("rst.irq", bus.irq, 0);
      res = 1'b0;
      repeat (3) @(negedge clk);

      // TX 0x80, with an ignored request while busy
      tx_q.push_back(8'h80);
      bus.tx_data  = 8'h80;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      n = 0;
      chk("tx.ready_drop", bus.tx_ready, 0);
      while (bus.tx_ready !== 1'b1 && n < 400) begin
         bus.tx_valid = (n == 50);
         bus.tx_data  = (n == 50) ? 8'hFF : 8'h80;
         @(negedge clk);
         n++;
      end
      bus.tx_valid = 1'b0;
      chk("tx.ready_return_cycles", n, 10 * BC);
      repeat (5) @(negedge clk);

      // RX 0x39 then read
      rx_q.push_back(mk(8'h39, 1, 0, 0, 1));
      rx_frame(8'h39, 1'b1, 1'b0);
      rx_q.push_back(mk(8'h39, 0, 0, 0, 0));
      rd_pulse();

      // Short glitch, then 0xF1
      bus.sdi = 1'b0;
      repeat (BC / 4) @(negedge clk);
      bus.sdi = 1'b1;
      repeat (3 * BC) @(negedge clk);
      rx_q.push_back(mk(8'hF1, 1, 0, 0, 1));
      rx_frame(8'hF1, 1'b1, 1'b0);
      rx_q.push_back(mk(8'hF1, 0, 0, 0, 0));
      rd_pulse();

      // Framing error: byte discarded, rx_data keeps 0xF1
      rx_q.push_back(mk(8'hF1, 0, 1, 0, 1));
      rx_frame(8'h55, 1'b0, 1'b0);
      rx_q.push_back(mk(8'hF1, 0, 0, 0, 0));
      rd_pulse();

      // Overrun, then read coincident with a good stop sample
      rx_q.push_back(mk(8'h12, 1, 0, 0, 1));
      rx_frame(8'h12, 1'b1, 1'b0);
      rx_q.push_back(mk(8'h12, 1, 0, 1, 1));
      rx_frame(8'h34, 1'b1, 1'b0);
      rx_q.push_back(mk(8'h56, 1, 0, 0, 1));
      rx_frame(8'h56, 1'b1, 1'b1);
      #2 bus.irq_en = 1'b0;
      #1 chk("irq.gated_off", bus.irq, 0);
      bus.irq_en = 1'b1;
      @(negedge clk);
      rx_q.push_back(mk(8'h56, 0, 0, 0, 0));
      rd_pulse();

      // Reset with TX in bit 3 and RX in bit 5
      rxb = 8'hC3;
      for (int c = 0; c < 100; c++) begin
         if (c < 16) bus.sdi = 1'b0;
         else        bus.sdi = rxb[c / 16 - 1];
         bus.tx_valid = (c == 31);
         bus.tx_data  = 8'h3C;
         @(negedge clk);
      end
      res = 1'b1;
      #1;
      chk("midrst.sdo", bus.sdo, 1);
      chk("midrst.tx_ready", bus.tx_ready, 1);
      chk("midrst.rx_data", bus.rx_data, 8'h00);
      chk("midrst.rx_full", bus.rx_full, 0);
      chk("midrst.fe", bus.fe, 0);
      chk("midrst.ovr", bus.ovr, 0);
      chk("midrst.irq", bus.irq, 0);
      bus.sdi      = 1'b1;
      bus.tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      res = 1'b0;
      repeat (3) @(negedge clk);

      // Full duplex after reset: TX 0xA5 while receiving 0x5A
      tx_q.push_back(8'hA5);
      bus.tx_data  = 8'hA5;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      rx_q.push_back(mk(8'h5A, 1, 0, 0, 1));
      rx_frame(8'h5A, 1'b1, 1'b0);
      rx_q.push_back(mk(8'h5A, 0, 0, 0, 0));
      rd_pulse();

      n = 0;
      while ((rx_q.size() != 0 || tx_q.size() != 0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("scoreboard_drained", rx_q.size() + tx_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Absolute time bound.
   initial begin
      #500000;
      n_tests++;
      n_fail++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
